// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential 32-iteration multiply/divide engine with HI/LO result
// registers and a move-from-HI/LO write port into the register bench.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int ADDR  = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             mfReq,
    input  logic             mfSel,
    input  logic [ADDR-1:0]  mfAddy,
    output logic             busy,
    output logic             done,
    output logic             mfStall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [ADDR-1:0]  writeAddy,
    output logic [WIDTH-1:0] writeData,
    output logic             cu_writeReg
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state, stateNext;
    logic [CW-1:0]    count;
    logic             isDiv, negRes, negRem, divZero;
    logic [WIDTH-1:0] acc, shreg, mcand, rawA;
    logic [WIDTH-1:0] magA, magB, divRem;
    logic [WIDTH:0]   mulSum, divShift;
    logic [2*WIDTH-1:0] product;
    logic             divFits, mfAccept;

    assign magA = (op[0] && operandA[WIDTH-1]) ? -operandA : operandA;
    assign magB = (op[0] && operandB[WIDTH-1]) ? -operandB : operandB;

    // acc holds the product high half (mult) or partial remainder (div);
    // shreg shifts out multiplier bits or shifts in quotient bits.
    assign mulSum   = {1'b0, acc} + (shreg[0] ? {1'b0, mcand} : '0);
    assign divShift = {acc, shreg[WIDTH-1]};
    assign divFits  = divShift >= {1'b0, mcand};
    assign divRem   = divFits ? WIDTH'(divShift - {1'b0, mcand}) : divShift[WIDTH-1:0];
    assign product  = negRes ? -{acc, shreg} : {acc, shreg};

    assign busy     = state != IDLE;
    assign done     = state == DONE;
    assign mfAccept = mfReq && (state == IDLE || state == DONE);
    assign mfStall  = mfReq && (state == RUN || state == FIX);

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: stateNext = start ? RUN : IDLE;
            RUN:  stateNext = (count == CW'(WIDTH - 1)) ? FIX : RUN;
            FIX:  stateNext = DONE;
            DONE: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            count       <= '0;
            isDiv       <= 1'b0;
            negRes      <= 1'b0;
            negRem      <= 1'b0;
            divZero     <= 1'b0;
            acc         <= '0;
            shreg       <= '0;
            mcand       <= '0;
            rawA        <= '0;
            hi          <= '0;
            lo          <= '0;
            writeAddy   <= '0;
            writeData   <= '0;
            cu_writeReg <= 1'b0;
        end else begin
            state       <= stateNext;
            cu_writeReg <= mfAccept;
            if (mfAccept) begin
                writeAddy <= mfAddy;
                writeData <= mfSel ? hi : lo;
            end
            if (state == IDLE && start) begin
                count   <= '0;
                isDiv   <= op[1];
                negRes  <= op[0] && (operandA[WIDTH-1] ^ operandB[WIDTH-1]);
                negRem  <= op[0] && operandA[WIDTH-1];
                divZero <= operandB == '0;
                acc     <= '0;
                shreg   <= magA;
                mcand   <= magB;
                rawA    <= operandA;
            end else if (state == RUN) begin
                count <= count + 1'b1;
                acc   <= isDiv ? divRem : mulSum[WIDTH:1];
                shreg <= isDiv ? {shreg[WIDTH-2:0], divFits} : {mulSum[0], shreg[WIDTH-1:1]};
            end else if (state == FIX) begin
                hi <= !isDiv ? product[2*WIDTH-1:WIDTH] : divZero ? rawA : negRem ? -acc : acc;
                lo <= !isDiv ? product[WIDTH-1:0] : divZero ? '1 : negRes ? -shreg : shreg;
            end
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed scenario tests for mult_div_unit with
// hand-computed HI/LO results, latency and move-from-HI/LO checks.
module tb_mult_div_unit;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operandA = '0;
    logic [31:0] operandB = '0;
    logic        mfReq = 1'b0;
    logic        mfSel = 1'b0;
    logic [4:0]  mfAddy = '0;
    logic        busy, done, mfStall, cu_writeReg;
    logic [31:0] hi, lo, writeData;
    logic [4:0]  writeAddy;

    int checkCount = 0;
    int passCount  = 0;

    mult_div_unit dut (
        .clock(clock), .reset_n(reset_n), .start(start), .op(op),
        .operandA(operandA), .operandB(operandB),
        .mfReq(mfReq), .mfSel(mfSel), .mfAddy(mfAddy),
        .busy(busy), .done(done), .mfStall(mfStall), .hi(hi), .lo(lo),
        .writeAddy(writeAddy), .writeData(writeData), .cu_writeReg(cu_writeReg)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic doStart(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start = 1'b1; op = o; operandA = a; operandB = b;
        @(posedge clock);
        #1;
        start = 1'b0; operandA = 32'hDEADBEEF; operandB = 32'h12345678;
    endtask

    // n = 1 at the first falling edge after the start edge
    task automatic waitDone(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!done && n < 100);
    endtask

    task automatic test_reset;
        #12;
        checkCount++;
        if ({hi, lo, writeData, writeAddy, busy, done, cu_writeReg, mfStall} !== '0)
            $display("FAIL reset_state: hi=%h lo=%h wd=%h wa=%h busy=%b done=%b we=%b, required all zero",
                     hi, lo, writeData, writeAddy, busy, done, cu_writeReg);
        else passCount++;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_multu;
        int n;
        doStart(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checkCount++;
        if (busy !== 1'b1) $display("FAIL multu_busy: busy=%b required 1", busy);
        else passCount++;
        waitDone(n);
        checkCount++;
        if (n !== 34) $display("FAIL multu_latency: done at cycle %0d required 34", n);
        else passCount++;
        checkCount++;
        if ({hi, lo} !== 64'hFFFFFFFE_00000001) $display("FAIL multu_result: %h_%h required FFFFFFFE_00000001", hi, lo);
        else passCount++;
        @(negedge clock);
        checkCount++;
        if ({busy, done} !== 2'b00) $display("FAIL multu_after: busy=%b done=%b required 0 0", busy, done);
        else passCount++;
    endtask

    task automatic test_signed;
        int n;
        doStart(2'b01, 32'hFFFFFFFD, 32'd7);
        waitDone(n);
        checkCount++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) $display("FAIL mult_neg3x7: %h_%h required FFFFFFFF_FFFFFFEB", hi, lo);
        else passCount++;
        doStart(2'b01, 32'h80000000, 32'd2);
        waitDone(n);
        checkCount++;
        if ({hi, lo} !== 64'hFFFFFFFF_00000000) $display("FAIL mult_min_x2: %h_%h required FFFFFFFF_00000000", hi, lo);
        else passCount++;
        doStart(2'b11, 32'hFFFFFFF9, 32'd2);
        waitDone(n);
        checkCount++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) $display("FAIL div_neg7_2: hi=%h lo=%h required FFFFFFFF FFFFFFFD", hi, lo);
        else passCount++;
        doStart(2'b11, 32'd7, 32'hFFFFFFFE);
        waitDone(n);
        checkCount++;
        if ({hi, lo} !== 64'h00000001_FFFFFFFD) $display("FAIL div_7_neg2: hi=%h lo=%h required 00000001 FFFFFFFD", hi, lo);
        else passCount++;
        doStart(2'b10, 32'd100, 32'd7);
        waitDone(n);
        checkCount++;
        if ({hi, lo} !== 64'h00000002_0000000E) $display("FAIL divu_100_7: hi=%h lo=%h required 00000002 0000000E", hi, lo);
        else passCount++;
    endtask

    task automatic test_div_boundary;
        int n;
        doStart(2'b10, 32'd100, 32'd0);
        waitDone(n);
        checkCount++;
        if (n !== 34) $display("FAIL divzero_latency: done at cycle %0d required 34", n);
        else passCount++;
        checkCount++;
        if ({hi, lo} !== 64'h00000064_FFFFFFFF) $display("FAIL divu_by_zero: hi=%h lo=%h required 00000064 FFFFFFFF", hi, lo);
        else passCount++;
        doStart(2'b11, 32'hFFFFFFF9, 32'd0);
        waitDone(n);
        checkCount++;
        if ({hi, lo} !== 64'hFFFFFFF9_FFFFFFFF) $display("FAIL div_by_zero: hi=%h lo=%h required FFFFFFF9 FFFFFFFF", hi, lo);
        else passCount++;
        doStart(2'b11, 32'h80000000, 32'hFFFFFFFF);
        waitDone(n);
        checkCount++;
        if ({hi, lo} !== 64'h00000000_80000000) $display("FAIL div_overflow: hi=%h lo=%h required 00000000 80000000", hi, lo);
        else passCount++;
    endtask

    task automatic test_mf_stall;
        int n;
        int bad;
        doStart(2'b00, 32'h00010000, 32'h00030000);
        mfReq = 1'b1; mfSel = 1'b1; mfAddy = 5'd9;
        n = 0;
        bad = 0;
        do begin
            @(negedge clock);
            n++;
            if (!done && (mfStall !== 1'b1 || cu_writeReg !== 1'b0)) bad++;
        end while (!done && n < 100);
        checkCount++;
        if (n !== 34 || bad !== 0) $display("FAIL mf_stall: done cycle %0d bad cycles %0d required 34 and 0", n, bad);
        else passCount++;
        checkCount++;
        if ({mfStall, cu_writeReg} !== 2'b00) $display("FAIL mf_done_state: stall=%b we=%b required 0 0", mfStall, cu_writeReg);
        else passCount++;
        @(posedge clock);
        #1;
        mfReq = 1'b0;
        @(negedge clock);
        checkCount++;
        if ({cu_writeReg, writeAddy, writeData} !== {1'b1, 5'd9, 32'h3})
            $display("FAIL mf_held_write: we=%b addr=%0d data=%h required 1 9 00000003", cu_writeReg, writeAddy, writeData);
        else passCount++;
        @(negedge clock);
        checkCount++;
        if (cu_writeReg !== 1'b0) $display("FAIL mf_single_write: we=%b required 0", cu_writeReg);
        else passCount++;
    endtask

    task automatic test_mf_idle;
        int n;
        @(negedge clock);
        mfReq = 1'b1; mfSel = 1'b0; mfAddy = 5'd3;
        @(negedge clock);
        checkCount++;
        if ({cu_writeReg, writeAddy, writeData} !== {1'b1, 5'd3, 32'h0})
            $display("FAIL mf_lo: we=%b addr=%0d data=%h required 1 3 00000000", cu_writeReg, writeAddy, writeData);
        else passCount++;
        mfSel = 1'b1; mfAddy = 5'd4;
        @(negedge clock);
        checkCount++;
        if ({cu_writeReg, writeAddy, writeData} !== {1'b1, 5'd4, 32'h3})
            $display("FAIL mf_back_to_back: we=%b addr=%0d data=%h required 1 4 00000003", cu_writeReg, writeAddy, writeData);
        else passCount++;
        mfReq = 1'b0;
        @(negedge clock);
        checkCount++;
        if (cu_writeReg !== 1'b0) $display("FAIL mf_release: we=%b required 0", cu_writeReg);
        else passCount++;
        start = 1'b1; op = 2'b00; operandA = 32'd2; operandB = 32'd2;
        mfReq = 1'b1; mfSel = 1'b1; mfAddy = 5'd5;
        @(posedge clock);
        #1;
        start = 1'b0; mfReq = 1'b0;
        @(negedge clock);
        checkCount++;
        if ({cu_writeReg, writeAddy, writeData, busy} !== {1'b1, 5'd5, 32'h3, 1'b1})
            $display("FAIL mf_with_start: we=%b addr=%0d data=%h busy=%b required 1 5 00000003 1",
                     cu_writeReg, writeAddy, writeData, busy);
        else passCount++;
        waitDone(n);
        checkCount++;
        if ({hi, lo} !== 64'h00000000_00000004) $display("FAIL mf_start_result: %h_%h required 00000000_00000004", hi, lo);
        else passCount++;
    endtask

    task automatic test_back_to_back;
        int n;
        doStart(2'b00, 32'd5, 32'd6);
        repeat (5) @(negedge clock);
        start = 1'b1; op = 2'b10; operandA = 32'd1000; operandB = 32'd10;
        @(posedge clock);
        #1;
        start = 1'b0;
        waitDone(n);
        checkCount++;
        if (n !== 29) $display("FAIL ignore_start_latency: done %0d cycles later required 29", n);
        else passCount++;
        checkCount++;
        if ({hi, lo} !== 64'h00000000_0000001E) $display("FAIL ignore_start_result: %h_%h required 00000000_0000001E", hi, lo);
        else passCount++;
        repeat (3) @(negedge clock);
        checkCount++;
        if ({busy, hi, lo} !== {1'b0, 64'h00000000_0000001E}) $display("FAIL no_queued_op: busy=%b hi=%h lo=%h required 0 0 1E", busy, hi, lo);
        else passCount++;
    endtask

    task automatic test_reset_abort;
        int n;
        int dones;
        doStart(2'b10, 32'd1000, 32'd10);
        repeat (10) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checkCount++;
        if ({busy, done, hi, lo} !== '0) $display("FAIL abort_reset: busy=%b done=%b hi=%h lo=%h required all zero", busy, done, hi, lo);
        else passCount++;
        dones = 0;
        repeat (2) begin
            @(negedge clock);
            if (done) dones++;
        end
        reset_n = 1'b1;
        repeat (40) begin
            @(negedge clock);
            if (done) dones++;
        end
        checkCount++;
        if (dones !== 0) $display("FAIL abort_no_done: %0d done cycles required 0", dones);
        else passCount++;
        doStart(2'b10, 32'd1000, 32'd10);
        waitDone(n);
        checkCount++;
        if (n !== 34 || {hi, lo} !== 64'h00000000_00000064)
            $display("FAIL after_abort: cycle %0d hi=%h lo=%h required 34 0 64", n, hi, lo);
        else passCount++;
    endtask

    initial begin
        test_reset;
        test_multu;
        test_signed;
        test_div_boundary;
        test_mf_stall;
        test_mf_idle;
        test_back_to_back;
        test_reset_abort;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
